// File: rtl/stopwatch_pkg.sv
// Shared state encoding, tick-divider derivation and default timing constants
// for the stopwatch control stage.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVF   = 2'd3
  } sw_state_t;

  localparam int DEF_CLK_HZ      = 50_000_000;
  localparam int DEF_TICK_HZ     = 100;
  localparam int DEF_DB_CYCLES   = 500_000;
  localparam int DEF_SYNC_STAGES = 2;

  // System clocks per count-enable pulse; callers keep the result >= 2.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button front end: multi-flop synchronizer, stable-level debounce counter and
// a one-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_level_d1;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync     <= '0;
      r_cnt      <= '0;
      r_level    <= 1'b0;
      r_level_d1 <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], btn_raw};
      r_level_d1 <= r_level;
      // Any cycle of agreement restarts the stability window.
      if (w_synced == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_level <= w_synced;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level = r_level;
  assign press = r_level & ~r_level_d1;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced start/stop and clear buttons, IDLE/RUN/PAUSE/OVF
// state machine, count-enable prescaler and counter-chain clear pulse.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ      = DEF_CLK_HZ,
  parameter int TICK_HZ     = DEF_TICK_HZ,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_clr,
  input  logic       cout3,
  output logic       cin0,
  output logic       cnt_clr,
  output logic       running,
  output logic       overflow,
  output logic [1:0] dbg_state,
  output logic [1:0] dbg_levels
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PSC_LAST = PW'(DIV - 1);

  sw_state_t     r_state;
  logic [PW-1:0] r_psc;
  logic          r_cnt_clr;
  logic          w_ss_press;
  logic          w_clr_press;
  logic          w_ss_level;
  logic          w_clr_level;
  logic          w_tick;

  btn_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES)
  ) u_db_ss (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_ss),
    .level   (w_ss_level),
    .press   (w_ss_press)
  );

  btn_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES)
  ) u_db_clr (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_clr),
    .level   (w_clr_level),
    .press   (w_clr_press)
  );

  assign w_tick = (r_state == ST_RUN) && (r_psc == PSC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_psc     <= '0;
      r_cnt_clr <= 1'b0;
    end else begin
      r_cnt_clr <= 1'b0;
      // The prescaler advances in every RUN cycle, including the one RUN is left in.
      if (r_state == ST_RUN) begin
        r_psc <= (r_psc == PSC_LAST) ? '0 : r_psc + PW'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (w_clr_press) begin
            r_cnt_clr <= 1'b1;
          end else if (w_ss_press) begin
            r_state <= ST_RUN;
            r_psc   <= '0;
          end
        end
        ST_RUN: begin
          // A wrap of the digit chain outranks a simultaneous start/stop press.
          if (w_tick && cout3) begin
            r_state <= ST_OVF;
          end else if (w_ss_press) begin
            r_state <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (w_clr_press) begin
            r_state   <= ST_IDLE;
            r_psc     <= '0;
            r_cnt_clr <= 1'b1;
          end else if (w_ss_press) begin
            r_state <= ST_RUN;
          end
        end
        ST_OVF: begin
          if (w_clr_press) begin
            r_state   <= ST_IDLE;
            r_psc     <= '0;
            r_cnt_clr <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cin0       = w_tick;
  assign cnt_clr    = r_cnt_clr;
  assign running    = (r_state == ST_RUN);
  assign overflow   = (r_state == ST_OVF);
  assign dbg_state  = r_state;
  assign dbg_levels = {w_clr_level, w_ss_level};

endmodule
